// File: rtl/addsub_acc_pipe.sv
// Two-stage pipelined signed add/subtract unit with per-channel accumulators and valid/ready flow control.
// Optional saturation on overflow is enabled by defining ADDSUB_SAT_EN; otherwise results wrap.
module addsub_acc_pipe #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  localparam int CH_W    = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [CH_W-1:0]  ch,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [CH_W-1:0]  out_ch,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;

  logic             en;
  logic             s1_valid_reg;
  logic [1:0]       s1_op_reg;
  logic [CH_W-1:0]  s1_ch_reg;
  logic [WIDTH-1:0] s1_in1_reg;
  logic [WIDTH-1:0] s1_in2_reg;

  logic [WIDTH-1:0] acc_reg [CHANNELS];

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sum;
  logic             ovf_next;
  logic [WIDTH-1:0] res_next;
  logic             acc_wr;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // op[1] selects the accumulator as operand A; op[0] selects subtraction.
  always_comb begin
    opa      = s1_op_reg[1] ? acc_reg[s1_ch_reg] : s1_in1_reg;
    opb      = s1_op_reg[0] ? ~s1_in2_reg : s1_in2_reg;
    sum      = opa + opb + {{(WIDTH-1){1'b0}}, s1_op_reg[0]};
    ovf_next = (opa[MSB] == opb[MSB]) && (sum[MSB] != opa[MSB]);
`ifdef ADDSUB_SAT_EN
    if (ovf_next)
      res_next = opa[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      res_next = sum;
`else
    res_next = sum;
`endif
  end

  assign acc_wr = en && s1_valid_reg && s1_op_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_op_reg    <= '0;
      s1_ch_reg    <= '0;
      s1_in1_reg   <= '0;
      s1_in2_reg   <= '0;
    end else if (en) begin
      s1_valid_reg <= in_valid;
      s1_op_reg    <= op;
      s1_ch_reg    <= ch;
      s1_in1_reg   <= in1;
      s1_in2_reg   <= in2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_ch    <= '0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        out    <= res_next;
        out_ch <= s1_ch_reg;
        ovf    <= ovf_next;
      end
    end
  end

  // A clear wins over the write-back of an in-flight ACC op on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) acc_reg[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < CHANNELS; i++) acc_reg[i] <= '0;
    end else if (acc_wr) begin
      acc_reg[s1_ch_reg] <= res_next;
    end
  end

endmodule

// File: tb/tb_addsub_acc_pipe.sv
// Scoreboard bench for addsub_acc_pipe: directed ops push expected results, a monitor pops on each output handshake.
module tb_addsub_acc_pipe;

  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AADD = 2'b10, OP_ASUB = 2'b11;

`ifdef ADDSUB_SAT_EN
  localparam logic [15:0] SUB_OVF_RES = 16'h8000;
  localparam logic [15:0] ADD_OVF_RES = 16'h7FFF;
`else
  localparam logic [15:0] SUB_OVF_RES = 16'h7FFF;
  localparam logic [15:0] ADD_OVF_RES = 16'h8000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = '0;
  logic [2:0]  ch = '0;
  logic [15:0] in1 = '0;
  logic [15:0] in2 = '0;
  logic        clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out;
  logic [2:0]  out_ch;
  logic        ovf;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  chn;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  addsub_acc_pipe #(.WIDTH(16), .CHANNELS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .ch(ch), .in1(in1), .in2(in2), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_ch(out_ch), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] o, input logic [2:0] c, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] eres, input logic eov);
    bit ok = 1'b0;
    in_valid = 1'b1; op = o; ch = c; in1 = a; in2 = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept op=%0d ch=%0d", o, c);
    end else begin
      @(posedge clk);
      sb.push_back('{eres, c, eov});
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Monitor: one comparison set per output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_output actual=out 0x%0h ch %0d required=none", out, out_ch);
        end else begin
          e = sb.pop_front();
          $display("result out=0x%04h ch=%0d ovf=%0b expected out=0x%04h ch=%0d ovf=%0b",
                   out, out_ch, ovf, e.res, e.chn, e.ov);
          chk("out", 32'(out), 32'(e.res));
          chk("out_ch", 32'(out_ch), 32'(e.chn));
          chk("ovf", 32'(ovf), 32'(e.ov));
        end
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with latency check: accepted at edge k, visible only after edge k+1
    send(OP_ADD, 3'd1, 16'h1234, 16'h0001, 16'h1235, 1'b0);
    @(negedge clk);
    chk("latency_k", 32'(out_valid), 0);
    @(negedge clk);
    chk("latency_k1", 32'(out_valid), 1);
    @(posedge clk); #1;

    // SUB and overflow cases
    send(OP_SUB, 3'd2, 16'h0005, 16'h0007, 16'hFFFE, 1'b0);
    send(OP_SUB, 3'd4, 16'h8000, 16'h0001, SUB_OVF_RES, 1'b1);
    send(OP_ADD, 3'd7, 16'h7FFF, 16'h0001, ADD_OVF_RES, 1'b1);

    // Back-to-back accumulation on ch3, then an untouched channel
    send(OP_AADD, 3'd3, 16'hDEAD, 16'h0010, 16'h0010, 1'b0);
    send(OP_AADD, 3'd3, 16'h0000, 16'h0010, 16'h0020, 1'b0);
    send(OP_AADD, 3'd3, 16'h0000, 16'h0010, 16'h0030, 1'b0);
    send(OP_AADD, 3'd5, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    repeat (4) @(posedge clk); #1;

    // Six-op stream with a 3-cycle downstream stall in the middle
    fork
      begin
        send(OP_AADD, 3'd3, 16'h0000, 16'h0005, 16'h0035, 1'b0);
        send(OP_ADD,  3'd0, 16'h0002, 16'h0003, 16'h0005, 1'b0);
        send(OP_ASUB, 3'd3, 16'h0000, 16'h0005, 16'h0030, 1'b0);
        send(OP_SUB,  3'd2, 16'h0010, 16'h0004, 16'h000C, 1'b0);
        send(OP_AADD, 3'd1, 16'h0000, 16'h0100, 16'h0100, 1'b0);
        send(OP_ASUB, 3'd6, 16'h0000, 16'h0001, 16'hFFFF, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 0);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;

    // clr on the write-back edge of an ACC_ADD: result from old acc, acc cleared
    send(OP_AADD, 3'd3, 16'h0000, 16'h0010, 16'h0040, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    send(OP_AADD, 3'd3, 16'h0000, 16'h0001, 16'h0001, 1'b0);
    send(OP_AADD, 3'd1, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    repeat (4) @(posedge clk); #1;

    // Asynchronous reset while a result is held
    out_ready = 1'b0;
    send(OP_AADD, 3'd3, 16'h0000, 16'h0002, 16'h0003, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("held_valid", 32'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_out", 32'(out), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(OP_AADD, 3'd3, 16'h0000, 16'h0007, 16'h0007, 1'b0);
    send(OP_ASUB, 3'd1, 16'h0000, 16'h0000, 16'h0000, 1'b0);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_pending", 32'(sb.size()), 0);
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
